// File: rtl/dmem_access_ctrl.sv
// Data-memory port owner: CPU load/store lane handling plus a halted-mode dump sequencer.
// Optional macro DMEM_SIGN_EXT_EN adds i_cpu_unsigned and signed byte/half loads.
module dmem_access_ctrl #(
  parameter int NB_BITS    = 32,
  parameter int NB_DEPTH   = 8,
  parameter int NB_COL     = 4,
  parameter int DUMP_WORDS = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NB_BITS-1:0]  i_cpu_addr,
  input  logic [NB_BITS-1:0]  i_cpu_wdata,
  input  logic [1:0]          i_cpu_write_ctl,
  input  logic [1:0]          i_cpu_read_ctl,
`ifdef DMEM_SIGN_EXT_EN
  input  logic                i_cpu_unsigned,
`endif
  output logic [NB_BITS-1:0]  o_cpu_rdata,
  output logic                o_cpu_misalign,
  output logic [NB_DEPTH-1:0] o_mem_addr,
  output logic [NB_BITS-1:0]  o_mem_wdata,
  output logic [NB_COL-1:0]   o_mem_we,
  output logic                o_mem_re,
  input  logic [NB_BITS-1:0]  i_mem_rdata,
  input  logic                i_dbg_halted,
  input  logic                i_dbg_start,
  input  logic                i_dbg_ready,
  output logic [NB_BITS-1:0]  o_dbg_data,
  output logic                o_dbg_valid,
  output logic                o_dbg_done,
  output logic                o_dbg_abort
);

  typedef enum logic [2:0] {IDLE, RD, WT, SEND, DONE} state_t;
  localparam logic [NB_DEPTH-1:0] LAST_ADDR = NB_DEPTH'(DUMP_WORDS - 1);

  state_t              state;
  logic [NB_DEPTH-1:0] dump_addr;

  logic                wr_act, rd_req, cpu_busy, misalign;
  logic [1:0]          op_size, off;
  logic [NB_COL-1:0]   cpu_we;
  logic [NB_BITS-1:0]  cpu_wdata;
  logic                unused_addr_bits;

  logic                ld_pending, ld_sx;
  logic [1:0]          ld_size, ld_off;
  logic [NB_BITS-1:0]  rdata_q, load_data, shifted;

  assign unused_addr_bits = ^i_cpu_addr[NB_BITS-1:NB_DEPTH+2];

  // A write wins over a simultaneous read, so alignment is judged on the effective op.
  assign wr_act   = |i_cpu_write_ctl;
  assign rd_req   = |i_cpu_read_ctl;
  assign cpu_busy = wr_act | rd_req;
  assign op_size  = wr_act ? i_cpu_write_ctl : i_cpu_read_ctl;
  assign off      = i_cpu_addr[1:0];
  assign misalign = (op_size == 2'b10 && off[0]) || (op_size == 2'b11 && off != 2'b00);
  assign o_cpu_misalign = cpu_busy & misalign;

  always_comb begin
    cpu_we    = '0;
    cpu_wdata = i_cpu_wdata;
    case (op_size)
      2'b01: begin
        cpu_we    = NB_COL'(1) << off;
        cpu_wdata = {NB_COL{i_cpu_wdata[7:0]}};
      end
      2'b10: begin
        cpu_we    = off[1] ? {{(NB_COL/2){1'b1}}, {(NB_COL/2){1'b0}}}
                           : {{(NB_COL/2){1'b0}}, {(NB_COL/2){1'b1}}};
        cpu_wdata = {(NB_COL/2){i_cpu_wdata[15:0]}};
      end
      2'b11:   cpu_we = '1;
      default: cpu_we = '0;
    endcase
  end

  // CPU owns the port whenever it asks for it; the dump only reads in otherwise idle RD cycles.
  always_comb begin
    o_mem_addr  = i_cpu_addr[NB_DEPTH+1:2];
    o_mem_wdata = cpu_wdata;
    o_mem_we    = '0;
    o_mem_re    = 1'b0;
    if (cpu_busy) begin
      if (!misalign) begin
        if (wr_act) o_mem_we = cpu_we;
        else        o_mem_re = 1'b1;
      end
    end else if (state == RD) begin
      o_mem_addr = dump_addr;
      o_mem_re   = 1'b1;
    end
  end

`ifdef DMEM_SIGN_EXT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)                                  ld_sx <= 1'b0;
    else if (!wr_act && rd_req && !misalign)    ld_sx <= ~i_cpu_unsigned;
  end
`else
  assign ld_sx = 1'b0;
`endif

  assign shifted = i_mem_rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_size)
      2'b01:   load_data = {{(NB_BITS-8){ld_sx & shifted[7]}}, shifted[7:0]};
      2'b10:   load_data = {{(NB_BITS-16){ld_sx & shifted[15]}}, shifted[15:0]};
      default: load_data = i_mem_rdata;
    endcase
  end

  assign o_cpu_rdata = ld_pending ? load_data : rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ld_pending <= 1'b0;
      ld_size    <= 2'b00;
      ld_off     <= 2'b00;
      rdata_q    <= '0;
    end else begin
      ld_pending <= !wr_act && rd_req && !misalign;
      if (!wr_act && rd_req && !misalign) begin
        ld_size <= i_cpu_read_ctl;
        ld_off  <= off;
      end
      if (ld_pending) rdata_q <= load_data;
    end
  end

  // Dump sequencer; losing i_dbg_halted in any active state aborts back to word 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      dump_addr   <= '0;
      o_dbg_data  <= '0;
      o_dbg_valid <= 1'b0;
      o_dbg_done  <= 1'b0;
      o_dbg_abort <= 1'b0;
    end else begin
      o_dbg_done  <= 1'b0;
      o_dbg_abort <= 1'b0;
      if ((state == RD || state == WT || state == SEND) && !i_dbg_halted) begin
        state       <= IDLE;
        dump_addr   <= '0;
        o_dbg_valid <= 1'b0;
        o_dbg_abort <= 1'b1;
      end else begin
        case (state)
          IDLE: if (i_dbg_start && i_dbg_halted) state <= RD;
          RD:   if (!cpu_busy) state <= WT;
          WT: begin
            o_dbg_data  <= i_mem_rdata;
            o_dbg_valid <= 1'b1;
            state       <= SEND;
          end
          SEND: if (i_dbg_ready) begin
            o_dbg_valid <= 1'b0;
            if (dump_addr == LAST_ADDR) begin
              dump_addr  <= '0;
              o_dbg_done <= 1'b1;
              state      <= DONE;
            end else begin
              dump_addr <= dump_addr + 1'b1;
              state     <= RD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: CPU lane handling, misalignment, and the dump sequencer
// against a small synchronous memory model with known contents.
module tb_dmem_access_ctrl;
  localparam int NB_BITS    = 32;
  localparam int NB_DEPTH   = 8;
  localparam int NB_COL     = 4;
  localparam int DUMP_WORDS = 4;

  logic                i_clk, i_rst;
  logic [NB_BITS-1:0]  i_cpu_addr, i_cpu_wdata;
  logic [1:0]          i_cpu_write_ctl, i_cpu_read_ctl;
  logic                i_cpu_unsigned;
  logic [NB_BITS-1:0]  o_cpu_rdata;
  logic                o_cpu_misalign;
  logic [NB_DEPTH-1:0] o_mem_addr;
  logic [NB_BITS-1:0]  o_mem_wdata;
  logic [NB_COL-1:0]   o_mem_we;
  logic                o_mem_re;
  logic [NB_BITS-1:0]  i_mem_rdata;
  logic                i_dbg_halted, i_dbg_start, i_dbg_ready;
  logic [NB_BITS-1:0]  o_dbg_data;
  logic                o_dbg_valid, o_dbg_done, o_dbg_abort;

  logic [NB_BITS-1:0]  mem [2**NB_DEPTH];
  logic [NB_BITS-1:0]  exp_q[$];
  logic [NB_BITS-1:0]  got_q[$];
  int                  n_checks = 0;
  int                  n_fail   = 0;
  int                  done_cnt, words_at_done;

`ifdef DMEM_SIGN_EXT_EN
  localparam logic [NB_BITS-1:0] EXP_LB = 32'hFFFF_FFAB;
  localparam logic [NB_BITS-1:0] EXP_LH = 32'hFFFF_BEEF;
`else
  localparam logic [NB_BITS-1:0] EXP_LB = 32'h0000_00AB;
  localparam logic [NB_BITS-1:0] EXP_LH = 32'h0000_BEEF;
`endif

  dmem_access_ctrl #(
    .NB_BITS(NB_BITS), .NB_DEPTH(NB_DEPTH), .NB_COL(NB_COL), .DUMP_WORDS(DUMP_WORDS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_write_ctl(i_cpu_write_ctl), .i_cpu_read_ctl(i_cpu_read_ctl),
`ifdef DMEM_SIGN_EXT_EN
    .i_cpu_unsigned(i_cpu_unsigned),
`endif
    .o_cpu_rdata(o_cpu_rdata), .o_cpu_misalign(o_cpu_misalign),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
    .i_mem_rdata(i_mem_rdata),
    .i_dbg_halted(i_dbg_halted), .i_dbg_start(i_dbg_start), .i_dbg_ready(i_dbg_ready),
    .o_dbg_data(o_dbg_data), .o_dbg_valid(o_dbg_valid), .o_dbg_done(o_dbg_done),
    .o_dbg_abort(o_dbg_abort)
  );

  // Clock and memory model (synchronous read, per-column write)
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    for (int c = 0; c < NB_COL; c++)
      if (o_mem_we[c]) mem[o_mem_addr][8*c +: 8] <= o_mem_wdata[8*c +: 8];
    if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
  end

  // Drivers
  task automatic idle_cpu();
    i_cpu_write_ctl = 2'b00;
    i_cpu_read_ctl  = 2'b00;
    i_cpu_addr      = '0;
    i_cpu_wdata     = '0;
  endtask

  task automatic pulse_start();
    @(negedge i_clk); i_dbg_start = 1'b1;
    @(negedge i_clk); i_dbg_start = 1'b0;
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_dbg_valid) begin ok = 1'b1; break; end
      @(negedge i_clk); #1;
    end
  endtask

  // Samples from the current point onward; a word counts when valid&ready precede a posedge.
  task automatic collect_words(input int max_cycles);
    int tail;
    got_q.delete();
    done_cnt = 0; words_at_done = -1; tail = -1;
    for (int c = 0; c < max_cycles; c++) begin
      if (o_dbg_done) begin
        done_cnt++;
        if (words_at_done < 0) words_at_done = got_q.size();
        if (tail < 0) tail = 3;
      end
      if (o_dbg_valid && i_dbg_ready) got_q.push_back(o_dbg_data);
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(negedge i_clk); #1;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    n_checks++; if (o_dbg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_dbg_valid); end
    n_checks++; if (o_dbg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_dbg_done); end
    n_checks++; if (o_dbg_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", o_dbg_abort); end
    n_checks++; if (o_cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", o_cpu_rdata); end
    n_checks++; if (o_mem_re !== 1'b0 || o_mem_we !== '0) begin n_fail++; $display("FAIL reset_port: re=%b we=%b want 0/0000", o_mem_re, o_mem_we); end
    i_rst = 1'b0;
  endtask

  task automatic test_store_byte();
    @(negedge i_clk);
    i_cpu_write_ctl = 2'b01; i_cpu_addr = 32'h6; i_cpu_wdata = 32'h1234_56AB;
    #1;
    n_checks++; if (o_mem_we !== 4'b0100) begin n_fail++; $display("FAIL sb_we: got %b want 0100", o_mem_we); end
    n_checks++; if (o_mem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want ababab ab", o_mem_wdata); end
    n_checks++; if (o_mem_addr !== 8'd1 || o_mem_re !== 1'b0) begin n_fail++; $display("FAIL sb_addr: addr=%0d re=%b want 1/0", o_mem_addr, o_mem_re); end
    @(negedge i_clk); idle_cpu();
  endtask

  task automatic test_load_byte();
    @(negedge i_clk);
    i_cpu_read_ctl = 2'b01; i_cpu_addr = 32'h6; i_cpu_unsigned = 1'b0;
    #1;
    n_checks++; if (o_mem_re !== 1'b1 || o_mem_addr !== 8'd1) begin n_fail++; $display("FAIL lb_port: re=%b addr=%0d want 1/1", o_mem_re, o_mem_addr); end
    @(negedge i_clk); idle_cpu(); #1;
    n_checks++; if (o_cpu_rdata !== EXP_LB) begin n_fail++; $display("FAIL lb_rdata: got %h want %h", o_cpu_rdata, EXP_LB); end
    @(negedge i_clk); #1;
    n_checks++; if (o_cpu_rdata !== EXP_LB) begin n_fail++; $display("FAIL lb_hold: got %h want %h", o_cpu_rdata, EXP_LB); end
  endtask

  task automatic test_misalign();
    @(negedge i_clk);
    i_cpu_write_ctl = 2'b10; i_cpu_addr = 32'h3; i_cpu_wdata = 32'h0000_7777;
    #1;
    n_checks++; if (o_cpu_misalign !== 1'b1) begin n_fail++; $display("FAIL sh_mis: got %b want 1", o_cpu_misalign); end
    n_checks++; if (o_mem_we !== 4'b0000) begin n_fail++; $display("FAIL sh_mis_we: got %b want 0000", o_mem_we); end
    @(negedge i_clk); idle_cpu(); #1;
    n_checks++; if (o_cpu_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b want 0", o_cpu_misalign); end
    @(negedge i_clk);
    i_cpu_read_ctl = 2'b11; i_cpu_addr = 32'h5;
    #1;
    n_checks++; if (o_cpu_misalign !== 1'b1 || o_mem_re !== 1'b0) begin n_fail++; $display("FAIL lw_mis: mis=%b re=%b want 1/0", o_cpu_misalign, o_mem_re); end
    @(negedge i_clk); idle_cpu(); #1;
    n_checks++; if (o_cpu_rdata !== EXP_LB) begin n_fail++; $display("FAIL lw_mis_hold: got %h want %h", o_cpu_rdata, EXP_LB); end
  endtask

  task automatic test_load_word();
    @(negedge i_clk);
    i_cpu_read_ctl = 2'b11; i_cpu_addr = 32'h8;
    #1;
    n_checks++; if (o_mem_addr !== 8'd2 || o_mem_re !== 1'b1) begin n_fail++; $display("FAIL lw_port: addr=%0d re=%b want 2/1", o_mem_addr, o_mem_re); end
    @(negedge i_clk); idle_cpu(); #1;
    n_checks++; if (o_cpu_rdata !== 32'hCAFE_0002) begin n_fail++; $display("FAIL lw_rdata: got %h want cafe0002", o_cpu_rdata); end
  endtask

  task automatic test_half();
    @(negedge i_clk);
    i_cpu_write_ctl = 2'b10; i_cpu_addr = 32'hA; i_cpu_wdata = 32'h1234_BEEF;
    #1;
    n_checks++; if (o_mem_we !== 4'b1100) begin n_fail++; $display("FAIL sh_we: got %b want 1100", o_mem_we); end
    n_checks++; if (o_mem_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", o_mem_wdata); end
    @(negedge i_clk);
    idle_cpu(); i_cpu_read_ctl = 2'b10; i_cpu_addr = 32'hA; i_cpu_unsigned = 1'b0;
    @(negedge i_clk); idle_cpu(); #1;
    n_checks++; if (o_cpu_rdata !== EXP_LH) begin n_fail++; $display("FAIL lh_rdata: got %h want %h", o_cpu_rdata, EXP_LH); end
  endtask

  task automatic test_write_wins();
    @(negedge i_clk);
    i_cpu_write_ctl = 2'b11; i_cpu_read_ctl = 2'b11; i_cpu_addr = 32'h10; i_cpu_wdata = 32'h55AA_55AA;
    #1;
    n_checks++; if (o_mem_we !== 4'b1111 || o_mem_re !== 1'b0) begin n_fail++; $display("FAIL ww_port: we=%b re=%b want 1111/0", o_mem_we, o_mem_re); end
    n_checks++; if (o_mem_wdata !== 32'h55AA_55AA) begin n_fail++; $display("FAIL ww_wdata: got %h want 55aa55aa", o_mem_wdata); end
    @(negedge i_clk); idle_cpu(); #1;
    n_checks++; if (o_cpu_rdata !== EXP_LH) begin n_fail++; $display("FAIL ww_no_load: got %h want %h", o_cpu_rdata, EXP_LH); end
  endtask

  task automatic test_dump();
    i_dbg_halted = 1'b1; i_dbg_ready = 1'b1;
    pulse_start();
    collect_words(60);
    n_checks++; if (got_q.size() != DUMP_WORDS) begin n_fail++; $display("FAIL dump_count: got %0d want %0d", got_q.size(), DUMP_WORDS); end
    for (int i = 0; i < DUMP_WORDS && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL dump_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (done_cnt != 1 || words_at_done != DUMP_WORDS) begin n_fail++; $display("FAIL dump_done: pulses=%0d words_before=%0d want 1/%0d", done_cnt, words_at_done, DUMP_WORDS); end
  endtask

  task automatic test_backpressure();
    bit ok;
    i_dbg_ready = 1'b0;
    pulse_start();
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_valid_timeout: got 0 want 1"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk); #1;
      n_checks++; if (o_dbg_valid !== 1'b1 || o_dbg_data !== exp_q[0] || o_mem_re !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall%0d: valid=%b data=%h re=%b want 1/%h/0", c, o_dbg_valid, o_dbg_data, o_mem_re, exp_q[0]);
      end
    end
    i_dbg_ready = 1'b1;
    collect_words(60);
    n_checks++; if (got_q.size() != DUMP_WORDS) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), DUMP_WORDS); end
    for (int i = 0; i < DUMP_WORDS && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_cpu_preempt();
    i_dbg_ready = 1'b1;
    pulse_start();
    n_checks++; if (o_mem_re !== 1'b1 || o_mem_addr !== 8'd0) begin n_fail++; $display("FAIL pre_dump_rd: re=%b addr=%0d want 1/0", o_mem_re, o_mem_addr); end
    i_cpu_read_ctl = 2'b11; i_cpu_addr = 32'h8;
    #1;
    n_checks++; if (o_mem_addr !== 8'd2 || o_mem_re !== 1'b1) begin n_fail++; $display("FAIL pre_cpu_port: addr=%0d re=%b want 2/1", o_mem_addr, o_mem_re); end
    @(negedge i_clk); idle_cpu(); #1;
    n_checks++; if (o_cpu_rdata !== 32'hBEEF_0002) begin n_fail++; $display("FAIL pre_cpu_rdata: got %h want beef0002", o_cpu_rdata); end
    n_checks++; if (o_mem_re !== 1'b1 || o_mem_addr !== 8'd0 || o_dbg_valid !== 1'b0) begin
      n_fail++; $display("FAIL pre_retry: re=%b addr=%0d valid=%b want 1/0/0", o_mem_re, o_mem_addr, o_dbg_valid);
    end
    collect_words(60);
    n_checks++; if (got_q.size() != DUMP_WORDS) begin n_fail++; $display("FAIL pre_count: got %0d want %0d", got_q.size(), DUMP_WORDS); end
    for (int i = 0; i < DUMP_WORDS && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pre_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    i_dbg_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ab_valid%0d_timeout: got 0 want 1", k); end
      i_dbg_ready = 1'b1;
      @(negedge i_clk); i_dbg_ready = 1'b0; #1;
    end
    wait_valid(ok);
    n_checks++; if (!ok || o_dbg_data !== exp_q[2]) begin n_fail++; $display("FAIL ab_word2: valid=%b data=%h want 1/%h", ok, o_dbg_data, exp_q[2]); end
    i_dbg_halted = 1'b0;
    @(negedge i_clk); #1;
    n_checks++; if (o_dbg_abort !== 1'b1 || o_dbg_valid !== 1'b0) begin n_fail++; $display("FAIL ab_pulse: abort=%b valid=%b want 1/0", o_dbg_abort, o_dbg_valid); end
    i_dbg_halted = 1'b1;
    @(negedge i_clk); #1;
    n_checks++; if (o_dbg_abort !== 1'b0) begin n_fail++; $display("FAIL ab_pulse_len: got %b want 0", o_dbg_abort); end
    i_dbg_ready = 1'b1;
    pulse_start();
    collect_words(60);
    n_checks++; if (got_q.size() != DUMP_WORDS || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL ab_restart: count=%0d first=%h want %0d/%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0, DUMP_WORDS, exp_q[0]);
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ab_restart_done: got %0d pulses want 1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 2**NB_DEPTH; i++) mem[i] = '0;
    mem[0] = 32'h0A0B_0C0D;
    mem[1] = 32'h11AB_2233;
    mem[2] = 32'hCAFE_0002;
    mem[3] = 32'h3344_5566;
    i_mem_rdata = '0;
    i_cpu_unsigned = 1'b0;
    i_dbg_halted = 1'b0; i_dbg_start = 1'b0; i_dbg_ready = 1'b0;
    idle_cpu();
    // Dump contents after the CPU stores below (sh 0xBEEF into word 2 upper half)
    exp_q = '{32'h0A0B_0C0D, 32'h11AB_2233, 32'hBEEF_0002, 32'h3344_5566};

    test_reset();
    test_store_byte();
    test_load_byte();
    test_misalign();
    test_load_word();
    test_half();
    test_write_wins();
    test_dump();
    test_backpressure();
    test_cpu_preempt();
    test_abort();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
